// File: rtl/fetch_fd_if.sv
// fetch_fd_if: bundles the fetch stage's control, instruction-memory and
// F/D latch signals.
//
// Handshake: the stage has no valid/ready flow control. stall and redirect
// are level inputs sampled on every rising clock edge. fdValid qualifies
// fdInstruction/fdPC as a real fetched instruction. When fdValid is 0 the
// latch holds a bubble (NOP).
//
// Modports:
//   master - environment side: drives stall, redirect, redirectTarget and
//            q_imem, and observes everything the stage produces.
//   slave  - fetch stage side: the mirror of master.
//
// Signals:
//   stall          hazard unit asks the stage to hold the PC and F/D latch
//   redirect       a taken branch or jump resolved in execute
//   redirectTarget next PC when redirect is high
//   q_imem         instruction word at address_imem (combinational read)
//   address_imem   current PC
//   fdInstruction  latched instruction for decode
//   fdPC           PC+1 of the latched instruction
//   fdValid        latch holds a real instruction, not a bubble
//   fetchCount     instructions accepted into the latch (wraps)
//   bubbleCount    cycles the latch accepted nothing new (wraps)
//   fd_state       debug: action the stage took on the last edge
interface fetch_fd_if #(
    parameter int ADDR_W = 12
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirectTarget;
    logic [31:0]       q_imem;
    logic [ADDR_W-1:0] address_imem;
    logic [31:0]       fdInstruction;
    logic [ADDR_W-1:0] fdPC;
    logic              fdValid;
    logic [31:0]       fetchCount;
    logic [31:0]       bubbleCount;
    logic [1:0]        fd_state;

    modport master (
        output stall, redirect, redirectTarget, q_imem,
        input  address_imem, fdInstruction, fdPC, fdValid,
               fetchCount, bubbleCount, fd_state
    );

    modport slave (
        input  stall, redirect, redirectTarget, q_imem,
        output address_imem, fdInstruction, fdPC, fdValid,
               fetchCount, bubbleCount, fd_state
    );
endinterface

// File: rtl/fetch_fd_stage.sv
// fetch_fd_stage: program counter, instruction-memory addressing and the
// F/D pipeline latch of the five-stage processor.
//
// Each rising edge the stage takes exactly one action, chosen by priority:
//   reset    -> everything cleared, latch holds a bubble
//   redirect -> PC loads redirectTarget, latch squashed to a bubble
//   stall    -> PC and latch hold
//   else     -> latch captures q_imem and PC+1, PC advances
// PC arithmetic wraps modulo 2^ADDR_W. The counters wrap at 32 bits.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   fd     fetch_fd_if slave modport (see fetch_fd_if for signal list)
module fetch_fd_stage #(
    parameter int ADDR_W = 12
) (
    input logic     clock,
    input logic     reset,
    fetch_fd_if.slave fd
);
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fd_state_e;

    fd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic [ADDR_W-1:0] fdpc_q, fdpc_d;
    logic              valid_q, valid_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;
    logic [ADDR_W-1:0] pc_plus_one;

    // Natural truncation gives the modulo-2^ADDR_W wrap.
    assign pc_plus_one = pc_q + ADDR_W'(1);

    // Action selection. Redirect outranks stall, so a taken branch is
    // never lost behind a hazard.
    always_comb begin
        state_d = ST_RUN;
        if (reset) begin
            state_d = ST_RESET;
        end else if (fd.redirect) begin
            state_d = ST_SQUASH;
        end else if (fd.stall) begin
            state_d = ST_HOLD;
        end
    end

    // Next values for the datapath registers. They hold by default.
    always_comb begin
        pc_d         = pc_q;
        ins_d        = ins_q;
        fdpc_d       = fdpc_q;
        valid_d      = valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        case (state_d)
            ST_SQUASH: begin
                pc_d         = fd.redirectTarget;
                ins_d        = NOP;
                fdpc_d       = '0;
                valid_d      = 1'b0;
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            ST_HOLD: begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            ST_RUN: begin
                pc_d        = pc_plus_one;
                ins_d       = fd.q_imem;
                fdpc_d      = pc_plus_one;
                valid_d     = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            default: begin
                // ST_RESET is applied by the register process.
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RESET;
            pc_q         <= '0;
            ins_q        <= NOP;
            fdpc_q       <= '0;
            valid_q      <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ins_q        <= ins_d;
            fdpc_q       <= fdpc_d;
            valid_q      <= valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fd.address_imem  = pc_q;
    assign fd.fdInstruction = ins_q;
    assign fd.fdPC          = fdpc_q;
    assign fd.fdValid       = valid_q;
    assign fd.fetchCount    = fetch_cnt_q;
    assign fd.bubbleCount   = bubble_cnt_q;
    assign fd.fd_state      = state_q;
endmodule

// File: tb/tb_fetch_fd_stage.sv
// tb_fetch_fd_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic. Every cycle is checked against
// a behavioural model of the fetch stream.
module tb_fetch_fd_stage;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clock;
    logic reset;
    logic [31:0] imem [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_fd_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_fd_stage #(.ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .fd    (bus)
    );

    // ---------------- clock / memory ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_comb bus.q_imem = imem[bus.address_imem];

    // ---------------- behavioural model ----------------
    // The model keeps its own PC and reads its own memory image. It never
    // looks at DUT state.
    logic [ADDR_W-1:0] m_pc, m_fdpc;
    logic [31:0]       m_ins, m_fc, m_bc;
    logic              m_valid;
    bit                model_live = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = '0; m_ins = '0; m_fdpc = '0; m_valid = 0;
            m_fc = '0; m_bc = '0;
            model_live = 1;
        end else if (bus.redirect) begin
            m_pc = bus.redirectTarget; m_ins = '0; m_fdpc = '0; m_valid = 0;
            m_bc = m_bc + 1;
        end else if (bus.stall) begin
            m_bc = m_bc + 1;
        end else begin
            m_ins   = imem[m_pc];
            m_pc    = ADDR_W'((int'(m_pc) + 1) % DEPTH);
            m_fdpc  = m_pc;
            m_valid = 1;
            m_fc    = m_fc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every cycle once the model has seen a reset.
    always @(negedge clock) begin
        if (model_live) begin
            check("address_imem",  32'(bus.address_imem), 32'(m_pc));
            check("fdInstruction", bus.fdInstruction,     m_ins);
            check("fdPC",          32'(bus.fdPC),         32'(m_fdpc));
            check("fdValid",       32'(bus.fdValid),      32'(m_valid));
            check("fetchCount",    bus.fetchCount,        m_fc);
            check("bubbleCount",   bus.bubbleCount,       m_bc);
        end
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge. The call returns on the next
    // falling edge, after the rising edge has acted on them.
    task automatic step(input bit rst, input bit st, input bit rd, input int tgt);
        reset              = rst;
        bus.stall          = st;
        bus.redirect       = rd;
        bus.redirectTarget = ADDR_W'(tgt);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        check({"pin ", name}, act, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int tgt;
        for (int i = 0; i < DEPTH; i++) imem[i] = 32'(i + 32'h100);
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectTarget = '0;
        @(negedge clock);

        // Reset values
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pin("rst addr",   32'(bus.address_imem), 32'h0);
        pin("rst ins",    bus.fdInstruction,     32'h0);
        pin("rst fdpc",   32'(bus.fdPC),         32'h0);
        pin("rst valid",  32'(bus.fdValid),      32'h0);
        pin("rst fetch",  bus.fetchCount,        32'h0);
        pin("rst bubble", bus.bubbleCount,       32'h0);

        // Three free-running fetches
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        pin("run ins",    bus.fdInstruction,     32'h102);
        pin("run fdpc",   32'(bus.fdPC),         32'h3);
        pin("run addr",   32'(bus.address_imem), 32'h3);
        pin("run valid",  32'(bus.fdValid),      32'h1);
        pin("run fetch",  bus.fetchCount,        32'h3);
        pin("run bubble", bus.bubbleCount,       32'h0);

        // Stall two cycles while 0x101 sits in F/D
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        pin("pre-stall ins", bus.fdInstruction, 32'h101);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        pin("stall ins",    bus.fdInstruction,     32'h101);
        pin("stall addr",   32'(bus.address_imem), 32'h2);
        pin("stall bubble", bus.bubbleCount,       32'h2);
        pin("stall valid",  32'(bus.fdValid),      32'h1);
        step(0, 0, 0, 0);
        pin("release ins",   bus.fdInstruction, 32'h102);
        pin("release fdpc",  32'(bus.fdPC),     32'h3);
        pin("release fetch", bus.fetchCount,    32'h3);

        // Redirect from pc=5 to 0x040
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        pin("pre-redir addr", 32'(bus.address_imem), 32'h5);
        step(0, 0, 1, 'h040);
        pin("squash ins",    bus.fdInstruction,     32'h0);
        pin("squash valid",  32'(bus.fdValid),      32'h0);
        pin("squash addr",   32'(bus.address_imem), 32'h040);
        pin("squash bubble", bus.bubbleCount,       32'h3);
        step(0, 0, 0, 0);
        pin("target ins",   bus.fdInstruction, 32'h140);
        pin("target fdpc",  32'(bus.fdPC),     32'h041);
        pin("target valid", 32'(bus.fdValid),  32'h1);

        // Redirect together with stall
        step(0, 1, 1, 'h010);
        pin("rd+st addr",   32'(bus.address_imem), 32'h010);
        pin("rd+st valid",  32'(bus.fdValid),      32'h0);
        pin("rd+st ins",    bus.fdInstruction,     32'h0);
        pin("rd+st bubble", bus.bubbleCount,       32'h4);

        // Back-to-back redirects: only the last target is fetched
        step(0, 0, 1, 'h020);
        step(0, 0, 1, 'h030);
        step(0, 0, 0, 0);
        pin("b2b ins",    bus.fdInstruction, 32'h130);
        pin("b2b fdpc",   32'(bus.fdPC),     32'h031);
        pin("b2b bubble", bus.bubbleCount,   32'h6);

        // PC wrap at the top of the address space
        step(0, 0, 1, 'hFFF);
        step(0, 0, 0, 0);
        pin("wrap ins",   bus.fdInstruction,     32'h10FF);
        pin("wrap fdpc",  32'(bus.fdPC),         32'h0);
        pin("wrap addr",  32'(bus.address_imem), 32'h0);
        pin("wrap fetch", bus.fetchCount,        32'h8);

        // Reset in the middle of a stall
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        pin("rst-stall addr",   32'(bus.address_imem), 32'h0);
        pin("rst-stall ins",    bus.fdInstruction,     32'h0);
        pin("rst-stall valid",  32'(bus.fdValid),      32'h0);
        pin("rst-stall bubble", bus.bubbleCount,       32'h0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        pin("post-rst ins",  bus.fdInstruction, 32'h100);
        pin("post-rst fdpc", 32'(bus.fdPC),     32'h1);

        // Randomized traffic over random memory contents
        for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 1) tgt = $urandom_range(DEPTH - 4, DEPTH - 1);
            else                           tgt = $urandom_range(0, DEPTH - 1);
            step(r < 2, $urandom_range(0, 3) == 0, (r >= 2) && (r < 14), tgt);
        end
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_fd_stage.md
# fetch_fd_stage

Fetch stage plus F/D pipeline latch for the five-stage processor. Owns the program counter, drives the instruction-memory address, captures the fetched word into the F/D latch, and presents it as the instruction consumed by the decode-side register-port decoder. Handles hazard stalls, squashes on taken branch/jump redirects, and keeps two wrapping performance counters.

## Interface
- ADDR_W, 12, instruction-memory word-address width (PC width)
- clock  in  1  rising-edge clock; sole clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and F/D latch this cycle
- redirect  in  1  execute stage: taken branch/jump, load redirectTarget
- redirectTarget  in  ADDR_W  next PC on redirect
- q_imem  in  32  instruction word at address_imem (combinational read)
- address_imem  out  ADDR_W  current PC
- fdInstruction  out  32  latched instruction to decode
- fdPC  out  ADDR_W  latched PC+1 of that instruction (for branch/jal)
- fdValid  out  1  fdInstruction is a real fetched instruction, not a bubble
- fetchCount  out  32  instructions accepted into F/D
- bubbleCount  out  32  cycles F/D did not accept a new instruction

Clock is `clock`, reset is `reset`: one clock domain, reset synchronous and active-high.

## Operation
- Registers: pc, fdInstruction, fdPC, fdValid, fetchCount, bubbleCount. address_imem = pc (combinational).
- NOP = 32'h0000_0000 (add $0,$0,$0).
- Per-edge priority, highest first:
  - reset: pc=0, fdInstruction=NOP, fdPC=0, fdValid=0, fetchCount=0, bubbleCount=0.
  - redirect: pc=redirectTarget; fdInstruction=NOP; fdPC=0; fdValid=0; bubbleCount+1. Applies even if stall is high.
  - stall: pc, fdInstruction, fdPC, fdValid hold; bubbleCount+1.
  - otherwise (advance): fdInstruction=q_imem; fdPC=pc+1; fdValid=1; pc=pc+1; fetchCount+1.
- PC arithmetic modulo 2^ADDR_W: pc=2^ADDR_W-1 advances to 0; fdPC for that word is 0.
- Counters wrap 0xFFFF_FFFF -> 0, no saturation, no flag.
- No decoding of q_imem; instruction content never affects control.
- Effective states: RESET, RUN (advance), HOLD (stall), SQUASH (redirect); all transitions are per-cycle from the inputs above, no multi-cycle sequences.

## Timing
- All outputs registered except address_imem (follows pc same cycle).
- Reset values: address_imem=0, fdInstruction=0, fdPC=0, fdValid=0, fetchCount=0, bubbleCount=0.
- Fetch latency: word at address A appears on fdInstruction one edge after pc=A with stall=0, redirect=0.
- Redirect latency: first edge with redirect=1 puts NOP in F/D; next advance edge latches q_imem[redirectTarget]; target instruction valid on fdInstruction two edges after redirect asserts (one bubble).
- Stall for N cycles: F/D contents and pc frozen N edges, bubbleCount +N; no instruction lost or duplicated.
- Reset asserted mid-stall or mid-redirect: reset wins that edge; first fetch after reset deasserts is address 0.
- redirect and stall together: treated as redirect; stall ignored that edge.
- Back-to-back redirects: each edge loads its own target, each inserts one NOP; only last target fetched.

## Test plan
- Reset then free run, imem[i]=i+0x100: after 3 advance edges fdInstruction=0x102, fdPC=3, address_imem=3, fdValid=1, fetchCount=3, bubbleCount=0.
- Stall 2 cycles with fdInstruction=0x101: holds 0x101, pc holds 2, bubbleCount=2; release -> next edge fdInstruction=0x102, no skipped or repeated word.
- Redirect to 0x040 while pc=5: next edge fdInstruction=0, fdValid=0, address_imem=0x040; following edge fdInstruction=0x140, fdPC=0x041, fdValid=1.
- redirect=1 and stall=1 same cycle, target 0x010: redirect taken, pc=0x010, F/D squashed, bubbleCount+1 only once.
- PC wrap: force redirect to 0xFFF then advance: fdPC=0x000, address_imem=0x000; fetchCount preloaded near 0xFFFF_FFFF via run wraps to 0.
- Reset asserted during 3-cycle stall: all outputs to reset values on that edge; first post-reset fetch from address 0.
